// File: rtl/ex_multicycle_divider_if.sv
// Bus between the EX stage / stall controller and the multicycle divider.
// The divider owns request_from_ex, done and the result; everything else is driven by the pipeline.
interface ex_multicycle_divider_if #(
  parameter int WIDTH = 32
);
  // Handshake: start is a level that stays high while EX holds a divide op. The divider
  // answers with request_from_ex (stall EX and earlier stages) until the result is ready.
  // done is high for the single cycle in which quotient/remainder are valid and EX may advance;
  // stall_all freezes that cycle and flush kills the op without producing a result.
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             stall_all;
  logic             flush;
  logic             request_from_ex;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor, stall_all, flush,
    input  request_from_ex, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor, stall_all, flush,
    output request_from_ex, done, quotient, remainder
  );
endinterface

// File: rtl/ex_multicycle_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX; stalls the pipeline while it works.
// One quotient bit per BUSY cycle, magnitudes only, signs restored when entering DONE.
module ex_multicycle_divider #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ex_multicycle_divider_if.slave bus,
  output logic [1:0]             dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] rem_work;
  logic [WIDTH-1:0] div_mag;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_it;
  logic [WIDTH-1:0] q_it;
  logic             last;
  logic             div_zero;

  assign div_zero = (bus.divisor == '0);
  assign last     = (count == CW'(WIDTH - 1));
  assign dvd_mag  = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign dsr_mag  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // Shifted remainder kept at WIDTH+1 bits so large unsigned divisors never lose the top bit.
  assign rem_sh = {rem_work, q_work[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, div_mag};
  assign take   = ~diff[WIDTH];
  assign rem_it = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign q_it   = {q_work[WIDTH-2:0], take};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_IDLE;
    end else if (!bus.stall_all) begin
      case (state)
        S_IDLE:  if (bus.start) state_nxt = div_zero ? S_DONE : S_BUSY;
        S_BUSY:  if (last) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      q_work      <= '0;
      rem_work    <= '0;
      div_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else if (!bus.stall_all) begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            count    <= '0;
            q_work   <= dvd_mag;
            rem_work <= '0;
            div_mag  <= dsr_mag;
            neg_q    <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r    <= bus.is_signed & bus.dividend[WIDTH-1];
            if (div_zero) begin
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
            end
          end
        end
        S_BUSY: begin
          count    <= count + CW'(1);
          q_work   <= q_it;
          rem_work <= rem_it;
          if (last) begin
            quotient_r  <= neg_q ? -q_it : q_it;
            remainder_r <= neg_r ? -rem_it : rem_it;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.request_from_ex = ~bus.flush & (((state == S_IDLE) & bus.start) | (state == S_BUSY));
  assign bus.done            = (state == S_DONE);
  assign bus.quotient        = quotient_r;
  assign bus.remainder       = remainder_r;
  assign dbg_state           = state;
endmodule

// File: tb/tb_ex_multicycle_divider.sv
// Directed and reference-model checks for the multicycle divider: latency, stall request,
// signed/unsigned results, divide by zero, overflow, stall_all, flush, reset and back-to-back ops.
module tb_ex_multicycle_divider;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad   = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  ex_multicycle_divider_if #(.WIDTH(W)) bus ();

  ex_multicycle_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Entered just after a rising edge with the divider in IDLE; leaves just after the edge
  // that follows the last DONE cycle, with start still high.
  task automatic do_div(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                        input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int stall_at, input int stall_len, input int done_stall);
    int   n = 1;
    int   req = 0;
    int   exp_done;
    logic fin = 1'b0;
    logic [W-1:0] q_e, r_e;
    exp_done = (dsr == '0) ? 2 : W + 2 + stall_len;
    exp_q.push_back(eq);
    exp_q.push_back(er);
    bus.start     = 1'b1;
    bus.dividend  = dvd;
    bus.divisor   = dsr;
    bus.is_signed = sgn;
    while (!fin) begin
      bus.stall_all = (n >= stall_at) && (n < stall_at + stall_len);
      @(negedge clk);
      if (n == 1) check({tag, " start_state"}, W'(dbg_state), 0);
      if (bus.done) begin
        fin = 1'b1;
      end else begin
        if (bus.request_from_ex) req++;
        n++;
        if (n > 200) begin
          check({tag, " timeout"}, W'(n), W'(exp_done));
          fin = 1'b1;
        end
        @(posedge clk);
        #1;
      end
    end
    q_e = exp_q.pop_front();
    r_e = exp_q.pop_front();
    check({tag, " done_cycle"}, W'(n), W'(exp_done));
    check({tag, " req_cycles"}, W'(req), W'(exp_done - 1));
    check({tag, " req_in_done"}, W'(bus.request_from_ex), 0);
    check({tag, " quotient"}, bus.quotient, q_e);
    check({tag, " remainder"}, bus.remainder, r_e);
    for (int i = 0; i < done_stall; i++) begin
      bus.stall_all = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check({tag, " done_held"}, W'(bus.done), 1);
      check({tag, " q_held"}, bus.quotient, q_e);
    end
    bus.stall_all = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] a, b, q, r;
    logic         s;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.stall_all = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst state", W'(dbg_state), 0);
    check("rst done", W'(bus.done), 0);
    check("rst req", W'(bus.request_from_ex), 0);
    check("rst q", bus.quotient, 0);
    check("rst r", bus.remainder, 0);
    @(posedge clk);
    #1;

    do_div("divu_100_7", 100, 7, 1'b0, 14, 2, 0, 0, 0);
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_after_done", W'(dbg_state), 0);
    @(posedge clk);
    #1;
    do_div("div_m7_2", 32'hFFFF_FFF9, 2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 0);
    do_div("div_7_m2", 7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 1, 0, 0, 0);
    do_div("divu_5_0", 5, 0, 1'b0, 32'hFFFF_FFFF, 5, 0, 0, 0);
    do_div("div_m9_0", 32'hFFFF_FFF7, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 0, 0, 0);
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 0, 0, 0);
    do_div("divu_max_1", 32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    do_div("divu_max_big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1, 1, 0, 0, 0);
    do_div("divu_lt", 32'h8000_0000, 32'h8000_0001, 1'b0, 0, 32'h8000_0000, 0, 0, 0);
    do_div("stall_busy", 100, 7, 1'b0, 14, 2, 10, 5, 0);
    do_div("stall_done", 20, 3, 1'b0, 6, 2, 0, 0, 3);
    bus.start = 1'b0;
    @(posedge clk);
    #1;

    // Flush in the middle of BUSY, then a clean restart.
    bus.start    = 1'b1;
    bus.dividend = 100;
    bus.divisor  = 7;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush req", W'(bus.request_from_ex), 0);
    check("flush busy", W'(dbg_state), 1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("flush idle", W'(dbg_state), 0);
    check("flush no_done", W'(bus.done), 0);
    @(posedge clk);
    #1;
    do_div("after_flush", 100, 7, 1'b0, 14, 2, 0, 0, 0);

    // Reset in the middle of BUSY discards the op and clears the held result.
    repeat (19) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst state", W'(dbg_state), 0);
    check("midrst done", W'(bus.done), 0);
    check("midrst req", W'(bus.request_from_ex), 0);
    check("midrst q", bus.quotient, 0);
    check("midrst r", bus.remainder, 0);
    @(posedge clk);
    #1;

    do_div("b2b_20_3", 20, 3, 1'b0, 6, 2, 0, 0, 0);
    do_div("b2b_9_4", 9, 4, 1'b0, 2, 1, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      s = 1'(($urandom_range(0, 1)));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = W'($urandom_range(1, 20));
        2:       b = (i % 8 == 0) ? '0 : -W'($urandom_range(1, 20));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(a, b, s, q, r);
      do_div("rand", a, b, s, q, r, 0, 0, 0);
    end
    bus.start = 1'b0;
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
